// File: rtl/dendy_pkg.sv
// Shared definitions for the Dendy sprite DMA engine.
package dendy_pkg;

  localparam int unsigned IDX_W = 8;
  localparam logic [15:0] REG_ADDR_DEFAULT = 16'h4014;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_e;

endpackage

// File: rtl/dendy_oam_dma.sv
// Sprite DMA: a CPU write of a page number to REG_ADDR copies LEN bytes from that
// page into OAM starting at the sampled OAMADDR, stalling the CPU meanwhile.
module dendy_oam_dma
  import dendy_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned LEN      = 256,
  parameter int unsigned OAMW     = 8,
  parameter logic [AW-1:0] REG_ADDR = AW'(REG_ADDR_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [AW-1:0]   cpu_a,
  input  logic [7:0]      cpu_o,
  input  logic            cpu_w,
  input  logic [OAMW-1:0] oam_base,
  output logic            cpu_halt,
  output logic [AW-1:0]   dma_a,
  output logic            dma_r,
  input  logic [7:0]      dma_i,
  output logic [OAMW-1:0] oam_a,
  output logic [7:0]      oam_o,
  output logic            oam_w,
  output logic            busy,
  output logic            done
);

  localparam int unsigned PW = AW - 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

  dma_state_e      state, state_d;
  logic [PW-1:0]   page, page_d;
  logic [OAMW-1:0] base, base_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic            parity, parity_d;
  logic            cpu_halt_d, busy_d, done_d, dma_r_d, oam_w_d;
  logic [AW-1:0]   dma_a_d;
  logic [OAMW-1:0] oam_a_d;
  logic [7:0]      oam_o_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      page     <= '0;
      base     <= '0;
      idx      <= '0;
      parity   <= 1'b0;
      cpu_halt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dma_r    <= 1'b0;
      dma_a    <= '0;
      oam_a    <= '0;
      oam_o    <= '0;
      oam_w    <= 1'b0;
    end else begin
      state    <= state_d;
      page     <= page_d;
      base     <= base_d;
      idx      <= idx_d;
      parity   <= parity_d;
      cpu_halt <= cpu_halt_d;
      busy     <= busy_d;
      done     <= done_d;
      dma_r    <= dma_r_d;
      dma_a    <= dma_a_d;
      oam_a    <= oam_a_d;
      oam_o    <= oam_o_d;
      oam_w    <= oam_w_d;
    end
  end

  // Next-state and next-output logic; strobes default low so they last one clock.
  always_comb begin
    state_d    = state;
    page_d     = page;
    base_d     = base;
    idx_d      = idx;
    parity_d   = parity ^ ce;
    cpu_halt_d = cpu_halt;
    busy_d     = busy;
    done_d     = 1'b0;
    dma_r_d    = 1'b0;
    dma_a_d    = dma_a;
    oam_a_d    = oam_a;
    oam_o_d    = oam_o;
    oam_w_d    = 1'b0;

    case (state)
      IDLE: begin
        if (ce && cpu_w && (cpu_a == REG_ADDR)) begin
          page_d     = cpu_o[PW-1:0];
          base_d     = oam_base;
          idx_d      = '0;
          busy_d     = 1'b1;
          cpu_halt_d = 1'b1;
          state_d    = HALT;
        end
      end
      HALT: begin
        if (ce) state_d = parity ? ALIGN : READ;
      end
      ALIGN: begin
        if (ce) state_d = READ;
      end
      READ: begin
        if (ce) begin
          dma_a_d = {page, idx};
          dma_r_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ce) begin
          oam_o_d = dma_i;
          oam_a_d = base + OAMW'(idx);
          oam_w_d = 1'b1;
          if (idx == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        cpu_halt_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
